// File: rtl/stream_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_manager_pkg
// Description : Shared constants for the stream manager AXI4-Lite register
//               block: AXI response codes, register count and register map.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_manager_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS_DEF = 4;

    // Register map (index = address bits [3:2])
    localparam int REG_CTRL = 0;
    localparam int REG_LEN  = 1;
    localparam int REG_CFG  = 2;
    localparam int REG_AUX  = 3;

endpackage
`default_nettype wire

// File: rtl/stream_manager_axil_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module      : stream_manager_axil_wr_fsm
// Description : AXI4-Lite write channel responder. Captures AW and W
//               independently, raises a one-cycle commit request once both
//               are held, and owns the B response channel.
//               Optional range checking: STREAM_MANAGER_AXIL_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_manager_axil_wr_fsm
    import stream_manager_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ready_en,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic                  o_commit,
    output logic                  o_commit_ok,
    output logic [1:0]            o_commit_idx,
    output logic [31:0]           o_commit_data,
    output logic [3:0]            o_commit_strb
);

    logic        r_aw_held;
    logic        r_aw_ok;
    logic [1:0]  r_idx;
    logic        r_w_held;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    logic        w_aw_ok;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_commit;
    logic        w_unused_addr;

`ifdef STREAM_MANAGER_AXIL_SLVERR_EN
    // Anything above the 16-byte register window is out of range
    assign w_aw_ok = ((i_awaddr >> 4) == '0);
`else
    // Upper address bits alias onto the register window
    assign w_aw_ok = 1'b1;
`endif
    assign w_unused_addr = ^i_awaddr;

    // Readies depend only on flops; no new write is taken while B is pending
    assign o_awready = i_ready_en & ~r_aw_held & ~r_bvalid;
    assign o_wready  = i_ready_en & ~r_w_held  & ~r_bvalid;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_w_hs    = i_wvalid  & o_wready;
    assign w_commit  = r_aw_held & r_w_held;

    // Hold the write address until both halves of the write are present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_idx     <= 2'd0;
        end else if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_ok   <= w_aw_ok;
            r_idx     <= i_awaddr[3:2];
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
        end
    end

    // Hold the write data and strobes until both halves are present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_held <= 1'b0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
        end else if (w_commit) begin
            r_w_held <= 1'b0;
        end
    end

    // Raise BVALID on the commit edge and hold it until BREADY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (i_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    assign o_bvalid      = r_bvalid;
    assign o_bresp       = r_bresp;
    assign o_commit      = w_commit;
    assign o_commit_ok   = r_aw_ok;
    assign o_commit_idx  = r_idx;
    assign o_commit_data = r_wdata;
    assign o_commit_strb = r_wstrb;

endmodule
`default_nettype wire

// File: rtl/stream_manager_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : stream_manager_axil_regs
// Description : AXI4-Lite responder and 4 x 32-bit control register file for
//               the stream manager. Byte-strobed writes with per-register
//               write pulses; single-outstanding, one-cycle-latency reads.
//               Optional range checking: STREAM_MANAGER_AXIL_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_manager_axil_regs
    import stream_manager_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = NUM_REGS_DEF
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          ctrl_reg,
    output logic [NUM_REGS-1:0]             wr_pulse
);

    logic        r_ready_en;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_commit;
    logic        w_commit_ok;
    logic [1:0]  w_commit_idx;
    logic [31:0] w_commit_data;
    logic [3:0]  w_commit_strb;
    logic [31:0] w_regs [NUM_REGS];
    logic [1:0]  w_ar_idx;
    logic        w_ar_ok;
    logic        w_ar_hs;
    logic        w_unused_prot;

    assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR};

    // Keep all readies low until the first edge after reset release
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    stream_manager_axil_wr_fsm #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
    ) u_wr_fsm (
        .clk           (S_AXI_ACLK),
        .rst_n         (S_AXI_ARESETN),
        .i_ready_en    (r_ready_en),
        .i_awaddr      (S_AXI_AWADDR),
        .i_awvalid     (S_AXI_AWVALID),
        .o_awready     (S_AXI_AWREADY),
        .i_wdata       (S_AXI_WDATA),
        .i_wstrb       (S_AXI_WSTRB),
        .i_wvalid      (S_AXI_WVALID),
        .o_wready      (S_AXI_WREADY),
        .o_bresp       (S_AXI_BRESP),
        .o_bvalid      (S_AXI_BVALID),
        .i_bready      (S_AXI_BREADY),
        .o_commit      (w_commit),
        .o_commit_ok   (w_commit_ok),
        .o_commit_idx  (w_commit_idx),
        .o_commit_data (w_commit_data),
        .o_commit_strb (w_commit_strb)
    );

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        logic [31:0] r_val;
        logic        r_pulse;
        logic        w_hit;

        assign w_hit = w_commit & w_commit_ok & (w_commit_idx == 2'(k));

        // Byte-merge committed data and strobe the matching write pulse
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                r_val   <= 32'd0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_hit;
                for (int b = 0; b < 4; b++) begin
                    if (w_hit && w_commit_strb[b]) begin
                        r_val[8*b +: 8] <= w_commit_data[8*b +: 8];
                    end
                end
            end
        end

        assign w_regs[k]             = r_val;
        assign ctrl_reg[32*k +: 32]  = r_val;
        assign wr_pulse[k]           = r_pulse;
    end

    assign w_ar_idx = S_AXI_ARADDR[3:2];
`ifdef STREAM_MANAGER_AXIL_SLVERR_EN
    assign w_ar_ok  = ((S_AXI_ARADDR >> 4) == '0);
`else
    assign w_ar_ok  = 1'b1;
`endif

    assign S_AXI_ARREADY = r_ready_en & ~r_rvalid;
    assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;

    // Capture read data on AR handshake (pre-write value on a commit edge)
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_ok ? w_regs[w_ar_idx] : 32'd0;
            r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_stream_manager_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_manager_axil_regs
// Description : Self-checking bench for stream_manager_axil_regs. A
//               transaction-level register model is checked against the DUT
//               every cycle, with directed and randomized AXI-Lite traffic.
//               Honours STREAM_MANAGER_AXIL_SLVERR_EN (uses 5-bit addresses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_manager_axil_regs;
    import stream_manager_pkg::*;

`ifdef STREAM_MANAGER_AXIL_SLVERR_EN
    localparam int AW = 5;
`else
    localparam int AW = 4;
`endif
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [NR*32-1:0] ctrl_reg;
    logic [NR-1:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    stream_manager_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_reg      (ctrl_reg),
        .wr_pulse      (wr_pulse)
    );

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0]   m_reg [NR] = '{default: 32'd0};
    bit            m_ren = 1'b0, m_haw = 1'b0, m_hw = 1'b0, m_bv = 1'b0, m_rv = 1'b0;
    logic [AW-1:0] m_awaddr = '0;
    logic [31:0]   m_wdata = '0;
    logic [3:0]    m_wstrb = '0;
    logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0]   m_rdata = '0;
    logic [NR-1:0] m_pulse = '0;

    function automatic bit in_range(input logic [AW-1:0] a);
`ifdef STREAM_MANAGER_AXIL_SLVERR_EN
        return (a >> 4) == 0;
`else
        return a == a;
`endif
    endfunction

    function automatic logic [NR*32-1:0] m_packed();
        logic [NR*32-1:0] v;
        for (int k = 0; k < NR; k++) v[32*k +: 32] = m_reg[k];
        return v;
    endfunction

    // Advance the model one clock: a write commits the cycle after both halves
    // have arrived; a read returns the register contents at its AR handshake.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) m_reg[k] = 32'd0;
            m_ren = 0; m_haw = 0; m_hw = 0; m_bv = 0; m_rv = 0;
            m_pulse = '0; m_rdata = '0; m_bresp = 2'b00; m_rresp = 2'b00;
        end else begin
            bit aw_hs, w_hs, ar_hs, commit;
            int idx;
            aw_hs  = awvalid && m_ren && !m_haw && !m_bv;
            w_hs   = wvalid  && m_ren && !m_hw  && !m_bv;
            ar_hs  = arvalid && m_ren && !m_rv;
            commit = m_haw && m_hw;
            if (ar_hs) begin
                m_rv    = 1;
                m_rdata = in_range(araddr) ? m_reg[int'(araddr[3:2])] : 32'd0;
                m_rresp = in_range(araddr) ? 2'b00 : 2'b10;
            end else if (m_rv && rready) begin
                m_rv = 0;
            end
            m_pulse = '0;
            if (commit) begin
                idx = int'(m_awaddr[3:2]);
                if (in_range(m_awaddr)) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_reg[idx][8*b +: 8] = m_wdata[8*b +: 8];
                    m_pulse[idx] = 1'b1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_bv = 1; m_haw = 0; m_hw = 0;
            end else if (m_bv && bready) begin
                m_bv = 0;
            end
            if (aw_hs) begin m_haw = 1; m_awaddr = awaddr; end
            if (w_hs)  begin m_hw = 1; m_wdata = wdata; m_wstrb = wstrb; end
            m_ren = 1;
        end
    end

    // Compare every DUT output against the model on each falling edge
    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("awready", awready, m_ren && !m_haw && !m_bv);
            chk("wready",  wready,  m_ren && !m_hw  && !m_bv);
            chk("arready", arready, m_ren && !m_rv);
            chk("bvalid",  bvalid,  m_bv);
            if (m_bv) chk("bresp", bresp, m_bresp);
            chk("rvalid",  rvalid,  m_rv);
            if (m_rv) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, m_rresp);
            end
            chk("ctrl_reg", ctrl_reg, m_packed());
            chk("wr_pulse", wr_pulse, m_pulse);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        int n;
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1 awaddr = a; awvalid = 1'b1;
                n = 0;
                do begin @(posedge clk); n++; end while (!(awvalid && awready) && n < 100);
                if (n >= 100) chk("aw_timeout", 1, 0);
                #1 awvalid = 1'b0;
            end
            begin
                int m;
                repeat (w_dly) @(posedge clk);
                #1 wdata = d; wstrb = s; wvalid = 1'b1;
                m = 0;
                do begin @(posedge clk); m++; end while (!(wvalid && wready) && m < 100);
                if (m >= 100) chk("w_timeout", 1, 0);
                #1 wvalid = 1'b0;
            end
        join
        repeat (b_dly) @(posedge clk);
        #1 bready = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; end while (!(bvalid && bready) && n < 100);
        if (n >= 100) chk("b_timeout", 1, 0);
        resp = bresp;
        #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int r_dly,
                           output logic [31:0] d, output logic [1:0] resp);
        int n;
        #1 araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; end while (!(arvalid && arready) && n < 100);
        if (n >= 100) chk("ar_timeout", 1, 0);
        #1 arvalid = 1'b0;
        repeat (r_dly) @(posedge clk);
        #1 rready = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; end while (!(rvalid && rready) && n < 100);
        if (n >= 100) chk("r_timeout", 1, 0);
        d = rdata; resp = rresp;
        #1 rready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] wvals [4];

        wvals[0] = 32'h1; wvals[1] = 32'h2; wvals[2] = 32'h3; wvals[3] = 32'h4;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl_reg", ctrl_reg, 128'd0);
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid, rdata}, 34'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic write of all four registers, then read back
        for (int k = 0; k < 4; k++) begin
            do_write(AW'(4 * k), wvals[k], 4'hF, 0, 0, 0, r);
            chk("wr_resp", r, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
            do_read(AW'(4 * k), 0, d, r);
            chk("rd_basic", d, wvals[k]);
            chk("rd_resp", r, 2'b00);
        end

        // Address/data ordering
        do_write(AW'(4'h8), 32'h0BAD_F00D, 4'hF, 3, 0, 0, r);
        do_write(AW'(4'hC), 32'hFEED_BEEF, 4'hF, 0, 3, 0, r);
        do_read(AW'(4'h8), 0, d, r);
        chk("rd_w_first", d, 32'h0BAD_F00D);

        // Byte strobes
        do_write(AW'(4'h4), 32'hAABB_CCDD, 4'hF, 0, 0, 0, r);
        do_write(AW'(4'h4), 32'h1122_3344, 4'b0101, 0, 0, 0, r);
        do_read(AW'(4'h4), 0, d, r);
        chk("rd_strobe", d, 32'hAA22_CC44);

        // Back-pressure on B and R
        do_write(AW'(4'h0), 32'h5555_AAAA, 4'hF, 0, 0, 5, r);
        do_read(AW'(4'h0), 5, d, r);
        chk("rd_stall", d, 32'h5555_AAAA);

        // Reset while AW is held and W is pending
        #1 awaddr = AW'(4'h8); awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 wvalid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", ctrl_reg, 128'd0);
        chk("mid_rst_bvalid", bvalid, 1'b0);
        do_write(AW'(4'h8), 32'h5A5A_0001, 4'hF, 0, 0, 0, r);
        chk("post_rst_resp", r, 2'b00);
        do_read(AW'(4'h8), 0, d, r);
        chk("post_rst_rd", d, 32'h5A5A_0001);

`ifdef STREAM_MANAGER_AXIL_SLVERR_EN
        do_write(AW'(5'h10), 32'h0000_DEAD, 4'hF, 0, 0, 0, r);
        chk("oor_bresp", r, 2'b10);
        chk("oor_reg0", ctrl_reg[31:0], 32'd0);
        do_read(AW'(5'h10), 0, d, r);
        chk("oor_rdata", d, 32'd0);
        chk("oor_rresp", r, 2'b10);
`endif

        // Randomized traffic, including concurrent read and write
        for (int i = 0; i < 200; i++) begin
            int op;
            logic [AW-1:0] wa, ra;
            logic [31:0]   wd, rd_d;
            logic [3:0]    ws;
            logic [1:0]    wr_r, rd_r;
            op = $urandom_range(0, 2);
            wa = AW'($urandom);
            ra = AW'($urandom);
            wd = $urandom;
            ws = 4'($urandom);
            if (op == 0) begin
                do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wr_r);
            end else if (op == 1) begin
                do_read(ra, $urandom_range(0, 3), rd_d, rd_r);
            end else begin
                fork
                    do_write(wa, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), wr_r);
                    do_read(ra, $urandom_range(0, 2), rd_d, rd_r);
                join
            end
        end

        repeat (3) @(posedge clk);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
